key_loader_c499: RTL and testbench
==================================

KEY_LOADER_C499 -- requirements
Module: key_loader_c499

Interface
REQ-001 The block SHALL have parameter KEY_W, default 29: key width. Bits [3:0] are p1..p4 (p1 = bit 0). Bits [28:4] are X_1..X_25 (X_1 = bit 4).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024: maximum idle cycles between accepted bits while loading.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin or restart a key load.
REQ-006 key_valid  input  1  serial bit strobe.
REQ-007 key_bit  input  1  serial key/parity data, LSB first.
REQ-008 key_ready  output  1  high only in SHIFT state.
REQ-009 key_out  output  KEY_W  key driven to the locked c499 netlist; all-zero unless key_locked.
REQ-010 key_locked  output  1  key_out holds a parity-verified key.
REQ-011 err  output  1  last load failed (parity or timeout).
REQ-012 load_cnt  output  5  number of frame bits accepted in the current load.

Function
REQ-013 The block SHALL implement a frame of KEY_W key bits followed by 1 even-parity bit, 30 bits total, with bit 0 first.
REQ-014 The block SHALL implement states IDLE, SHIFT, CHECK, ARMED, FAIL.
REQ-015 IDLE: start -> SHIFT. key_valid SHALL be ignored.
REQ-016 On entry to SHIFT:
- load_cnt = 0.
- shadow register = 0.
- timeout counter = 0.
- key_out = 0, key_locked = 0, err = 0, all on the same edge.
REQ-017 SHIFT: a bit is accepted on an edge where key_valid && key_ready. Key bits are stored at shadow[load_cnt], and load_cnt increments.
REQ-018 SHIFT: acceptance of the 30th bit (load_cnt == 29 before the edge) SHALL store the parity bit and go to CHECK. load_cnt then reads 30.
REQ-019 CHECK SHALL last exactly one cycle:
- XOR of shadow[KEY_W-1:0] and the parity bit == 0 -> ARMED. On that edge key_out <= shadow and key_locked <= 1.
- Otherwise -> FAIL, err <= 1, key_out stays 0.
REQ-020 key_locked and err SHALL become visible on the second rising edge after the edge that accepts the parity bit.
REQ-021 ARMED: key_out and key_locked SHALL hold stable indefinitely. start -> SHIFT, clearing them per REQ-016.
REQ-022 FAIL: err SHALL hold at 1. start -> SHIFT.
REQ-023 If start is asserted in SHIFT, the load SHALL restart per REQ-016. start has priority over a simultaneous key_valid, and that bit is discarded.
REQ-024 Timeout counter:
- Increments each SHIFT cycle with no accepted bit.
- Clears on each accepted bit.
- Reaching TIMEOUT -> FAIL with err = 1 on that edge.
REQ-025 key_valid outside SHIFT SHALL have no effect. start in CHECK SHALL be ignored.
REQ-026 key_out SHALL never expose partial shadow contents.

Reset
REQ-027 rst high at an edge SHALL force, from any state including mid-load:
- state = IDLE.
- key_out = 0, key_locked = 0, err = 0, key_ready = 0, load_cnt = 0.
- shadow = 0, timeout counter = 0.
REQ-028 rst SHALL dominate start and key_valid in the same cycle.

Verification
REQ-029 Key load, pass: start, then key 0x15555555 LSB first plus parity bit 1 (popcount 15), with key_valid continuous -> key_locked = 1 and key_out = 0x15555555 two edges after the parity bit; err = 0.
REQ-030 Key load, bad parity: same key with parity bit 0 -> err = 1, key_locked = 0, key_out = 0. A following start clears err.
REQ-031 Restart mid-load: start, 10 bits, start again, then key 0x0000001 with parity 1 -> load_cnt returns to 0 after the second start; final key_out = 0x0000001.
REQ-032 Timeout: TIMEOUT = 16, start, 5 bits, then key_valid low for 16 cycles -> FAIL, err = 1, key_ready = 0.
REQ-033 Reset while armed: load 0x1ABCDEF0 (parity 0, popcount 18), then rst for 1 cycle -> next cycle key_out = 0, key_locked = 0, state IDLE. key_valid pulses afterwards change nothing.
REQ-034 Gapped strobes: random gaps of 0-7 cycles between bits (< TIMEOUT), plus start and key_valid asserted together in SHIFT -> result matches an ungapped load, and the coincident bit is not counted.

Source files
------------

// File: rtl/key_loader_c499.sv
// -----------------------------------------------------------------------------
// key_loader_c499
//
// Serial key loader for a logic-locked c499 netlist. A frame of KEY_W key bits
// followed by one even-parity bit arrives LSB first, one bit per accepted
// key_valid strobe. Bits collect in a private shadow register. The key reaches
// key_out only after the whole frame has passed its parity check, so the
// locked netlist never sees a partially loaded key.
//
// Ports
//   clk         sole clock; all state updates on the rising edge
//   rst         synchronous, active-high reset
//   start       single-cycle request to begin or restart a load
//                 (ignored in CHECK)
//   key_valid   serial bit strobe; only has an effect in SHIFT
//   key_bit     serial key/parity data, LSB first
//   key_ready   high only while in SHIFT
//   key_out     verified key; all-zero unless key_locked
//   key_locked  key_out holds a parity-verified key
//   err         the last load failed (parity error or timeout)
//   load_cnt    number of frame bits accepted in the current load
//
// Parameters
//   KEY_W       key width. [3:0] = p1..p4, [KEY_W-1:4] = X_1..
//   TIMEOUT     maximum idle SHIFT cycles between accepted bits
// -----------------------------------------------------------------------------
module key_loader_c499 #(
  parameter int KEY_W   = 29,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_valid,
  input  logic             key_bit,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_locked,
  output logic             err,
  output logic [4:0]       load_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_ARMED,
    ST_FAIL
  } state_e;

  // The idle counter must be able to hold TIMEOUT itself.
  localparam int              TO_W       = $clog2(TIMEOUT + 1);
  // load_cnt equals KEY_W exactly when the next accepted bit is the parity bit.
  localparam logic [4:0]      PARITY_IDX = 5'(KEY_W);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

  state_e           state_q,      state_d;
  logic [KEY_W-1:0] shadow_q,     shadow_d;
  logic             parity_q,     parity_d;
  logic [TO_W-1:0]  idle_cnt_q,   idle_cnt_d;
  logic [4:0]       load_cnt_q,   load_cnt_d;
  logic [KEY_W-1:0] key_out_q,    key_out_d;
  logic             key_locked_q, key_locked_d;
  logic             err_q,        err_d;
  logic             key_ready_q,  key_ready_d;

  logic             restart;
  logic             parity_ok;

  // start is honoured everywhere except CHECK, so a verdict is never lost.
  assign restart = start && (state_q != ST_CHECK);

  // Even parity over key and parity bit: XOR of all frame bits must be zero.
  assign parity_ok = ((^shadow_q) ^ parity_q) == 1'b0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so that a path
    // that does not assign it holds the flop value and no latch is inferred.
    state_d      = state_q;
    shadow_d     = shadow_q;
    parity_d     = parity_q;
    idle_cnt_d   = idle_cnt_q;
    load_cnt_d   = load_cnt_q;
    key_out_d    = key_out_q;
    key_locked_d = key_locked_q;
    err_d        = err_q;

    if (restart) begin
      // Begin a fresh load. A key_valid in the same cycle is discarded, and
      // the previous key and verdict are withdrawn on this same edge.
      state_d      = ST_SHIFT;
      shadow_d     = '0;
      parity_d     = 1'b0;
      idle_cnt_d   = '0;
      load_cnt_d   = '0;
      key_out_d    = '0;
      key_locked_d = 1'b0;
      err_d        = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Waiting for start; key_valid has no effect here.
        end

        ST_SHIFT: begin
          if (key_valid) begin
            idle_cnt_d = '0;
            load_cnt_d = load_cnt_q + 5'd1;
            if (load_cnt_q == PARITY_IDX) begin
              parity_d = key_bit;
              state_d  = ST_CHECK;
            end else begin
              // Decoded write keeps the index width independent of KEY_W.
              for (int i = 0; i < KEY_W; i++) begin
                if (load_cnt_q == 5'(i)) begin
                  shadow_d[i] = key_bit;
                end
              end
            end
          end else begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
            if (idle_cnt_q == TO_LAST) begin
              state_d = ST_FAIL;
              err_d   = 1'b1;
            end
          end
        end

        ST_CHECK: begin
          // Single-cycle verdict. Only a verified key is published.
          if (parity_ok) begin
            state_d      = ST_ARMED;
            key_out_d    = shadow_q;
            key_locked_d = 1'b1;
          end else begin
            state_d = ST_FAIL;
            err_d   = 1'b1;
          end
        end

        ST_ARMED: begin
          // Hold the key until the next start.
        end

        ST_FAIL: begin
          // Hold err until the next start.
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // key_ready is registered from the next state, so it is a clean flop
    // output that is high exactly while state_q is SHIFT.
    key_ready_d = (state_d == ST_SHIFT);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so that every flop samples the values
  // computed before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow register is cleared on reset as well, so no stale
      // key bits survive an aborted load.
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      parity_q     <= 1'b0;
      idle_cnt_q   <= '0;
      load_cnt_q   <= '0;
      key_out_q    <= '0;
      key_locked_q <= 1'b0;
      err_q        <= 1'b0;
      key_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      parity_q     <= parity_d;
      idle_cnt_q   <= idle_cnt_d;
      load_cnt_q   <= load_cnt_d;
      key_out_q    <= key_out_d;
      key_locked_q <= key_locked_d;
      err_q        <= err_d;
      key_ready_q  <= key_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all driven directly from flops.
  // ---------------------------------------------------------------------------
  assign key_ready  = key_ready_q;
  assign key_out    = key_out_q;
  assign key_locked = key_locked_q;
  assign err        = err_q;
  assign load_cnt   = load_cnt_q;

endmodule

// File: tb/tb_key_loader_c499.sv
// -----------------------------------------------------------------------------
// tb_key_loader_c499
//
// Self-checking bench for key_loader_c499 (KEY_W = 29, TIMEOUT = 16).
// Expected values come from frame-level rules: a frame is 29 key bits plus a
// parity bit, and it passes when the total number of ones is even. A timeout
// occurs after 16 idle SHIFT cycles.
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_key_loader_c499;

  localparam int KEY_W   = 29;
  localparam int TIMEOUT = 16;
  localparam int FRAME   = KEY_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             key_valid;
  logic             key_bit;
  logic             key_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_locked;
  logic             err;
  logic [4:0]       load_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  key_loader_c499 #(.KEY_W(KEY_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_valid  (key_valid),
    .key_bit    (key_bit),
    .key_ready  (key_ready),
    .key_out    (key_out),
    .key_locked (key_locked),
    .err        (err),
    .load_cnt   (load_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: even parity over the whole frame.
  function automatic bit frame_passes(input logic [KEY_W-1:0] key, input logic par);
    return ((($countones(key) + int'(par)) % 2) == 0);
  endfunction

  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b exp 1", tag, key_ready); end
    n_checks++; if (load_cnt !== 5'd0) begin n_fail++; $display("FAIL %s_cnt: got %0d exp 0", tag, load_cnt); end
  endtask

  // Send frame bits 0..n-1 with random idle gaps of 0..max_gap cycles.
  task automatic send_bits(input logic [KEY_W-1:0] key, input logic par,
                           input int n, input int max_gap, input string tag);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      key_valid = 1'b0;
      repeat (g) step();
      key_valid = 1'b1;
      key_bit   = (i < KEY_W) ? key[i] : par;
      step();
      key_valid = 1'b0;
      n_checks++; if (load_cnt !== 5'(i + 1)) begin n_fail++; $display("FAIL %s_cnt[%0d]: got %0d exp %0d", tag, i, load_cnt, i + 1); end
      n_checks++; if (key_out !== '0) begin n_fail++; $display("FAIL %s_partial[%0d]: got %h exp 0", tag, i, key_out); end
    end
  endtask

  // Called right after the parity bit was accepted: one CHECK cycle, then the
  // verdict appears on the following edge.
  task automatic check_verdict(input logic [KEY_W-1:0] key, input logic par,
                               input bit start_in_check, input string tag);
    bit               pass;
    logic [KEY_W-1:0] exp_key;
    pass    = frame_passes(key, par);
    exp_key = pass ? key : '0;
    n_checks++; if (load_cnt !== 5'(FRAME)) begin n_fail++; $display("FAIL %s_cnt30: got %0d exp %0d", tag, load_cnt, FRAME); end
    n_checks++; if ({key_ready, key_locked, err} !== 3'b000) begin n_fail++; $display("FAIL %s_check_cycle: got rdy/lock/err %b exp 000", tag, {key_ready, key_locked, err}); end
    start = start_in_check;
    step();
    start = 1'b0;
    n_checks++; if (key_locked !== pass) begin n_fail++; $display("FAIL %s_locked: got %b exp %b", tag, key_locked, pass); end
    n_checks++; if (err !== !pass) begin n_fail++; $display("FAIL %s_err: got %b exp %b", tag, err, !pass); end
    n_checks++; if (key_out !== exp_key) begin n_fail++; $display("FAIL %s_key: got %h exp %h", tag, key_out, exp_key); end
    n_checks++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL %s_ready_after: got %b exp 0", tag, key_ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
    step();
    n_checks++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b exp 0", key_ready); end
    n_checks++; if (key_out !== '0) begin n_fail++; $display("FAIL reset_key: got %h exp 0", key_out); end
    n_checks++; if ({key_locked, err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b exp 00", {key_locked, err}); end
    n_checks++; if (load_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", load_cnt); end
    rst = 1'b0; start = 1'b0;
    // key_valid in IDLE is ignored.
    repeat (3) step();
    key_valid = 1'b0;
    n_checks++; if ({key_ready, load_cnt} !== 6'd0) begin n_fail++; $display("FAIL idle_ignore: got rdy %b cnt %0d exp 0/0", key_ready, load_cnt); end
  endtask

  task automatic test_pass();
    do_start("pass_start");
    send_bits(29'h15555555, 1'b1, FRAME, 0, "pass");
    check_verdict(29'h15555555, 1'b1, 1'b0, "pass");
    // The armed key holds indefinitely.
    repeat (5) step();
    n_checks++; if (key_out !== 29'h15555555 || key_locked !== 1'b1) begin n_fail++; $display("FAIL pass_hold: got %h/%b exp 15555555/1", key_out, key_locked); end
  endtask

  task automatic test_bad_parity();
    do_start("bad_start");
    send_bits(29'h15555555, 1'b0, FRAME, 0, "bad");
    check_verdict(29'h15555555, 1'b0, 1'b0, "bad");
    repeat (3) step();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_hold: got %b exp 1", err); end
    do_start("bad_restart");
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bad_clear: got %b exp 0", err); end
  endtask

  task automatic test_restart();
    do_start("rs_start");
    send_bits(29'h0ABCDEF, 1'b0, 10, 0, "rs_part");
    do_start("rs_again");
    send_bits(29'h0000001, 1'b1, FRAME, 0, "rs");
    check_verdict(29'h0000001, 1'b1, 1'b0, "rs");
  endtask

  task automatic test_timeout();
    do_start("to_start");
    send_bits(29'h1FFFFFFF, 1'b1, 5, 0, "to");
    key_valid = 1'b0;
    repeat (TIMEOUT - 1) step();
    n_checks++; if ({key_ready, err} !== 2'b10) begin n_fail++; $display("FAIL to_before: got rdy/err %b exp 10", {key_ready, err}); end
    step();
    n_checks++; if ({key_ready, err, key_locked} !== 3'b010) begin n_fail++; $display("FAIL to_expire: got rdy/err/lock %b exp 010", {key_ready, err, key_locked}); end
    n_checks++; if (key_out !== '0) begin n_fail++; $display("FAIL to_key: got %h exp 0", key_out); end
  endtask

  task automatic test_start_in_check();
    do_start("sic_start");
    send_bits(29'h0F0F0F0F, 1'b0, FRAME, 0, "sic");
    check_verdict(29'h0F0F0F0F, 1'b0, 1'b1, "sic");
  endtask

  task automatic test_reset_armed();
    do_start("ra_start");
    send_bits(29'h1ABCDEF0, 1'b0, FRAME, 0, "ra");
    check_verdict(29'h1ABCDEF0, 1'b0, 1'b0, "ra");
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (key_out !== '0 || key_locked !== 1'b0) begin n_fail++; $display("FAIL ra_reset: got %h/%b exp 0/0", key_out, key_locked); end
    key_bit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_valid = i[0];
      step();
    end
    key_valid = 1'b0;
    n_checks++; if ({key_ready, key_locked, err, load_cnt} !== 8'd0) begin n_fail++; $display("FAIL ra_idle: got rdy %b lock %b err %b cnt %0d exp all 0", key_ready, key_locked, err, load_cnt); end
    n_checks++; if (key_out !== '0) begin n_fail++; $display("FAIL ra_idle_key: got %h exp 0", key_out); end
  endtask

  task automatic test_gapped_random();
    for (int t = 0; t < 6; t++) begin
      logic [KEY_W-1:0] key;
      logic             par;
      int               cut;
      key = KEY_W'($urandom);
      par = 1'($urandom);
      cut = int'($urandom_range(FRAME - 1, 1));
      do_start("gap_start");
      send_bits(~key, ~par, cut, 7, "gap_pre");
      // start together with key_valid: restart wins, the bit is discarded.
      start = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
      step();
      start = 1'b0; key_valid = 1'b0;
      n_checks++; if (load_cnt !== 5'd0 || key_ready !== 1'b1) begin n_fail++; $display("FAIL gap_coincident[%0d]: got cnt %0d rdy %b exp 0/1", t, load_cnt, key_ready); end
      send_bits(key, par, FRAME, 7, "gap");
      check_verdict(key, par, 1'b0, "gap");
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
    test_reset();
    test_pass();
    test_bad_parity();
    test_restart();
    test_timeout();
    test_start_in_check();
    test_reset_armed();
    test_gapped_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
